// File: rtl/spi_frame_pkg.sv
// rtl/spi_frame_pkg.sv - state encoding, width helpers and JSTK2 command bytes for spi_frame_master
package spi_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_HOLD,
        S_DONE
    } state_t;

    function automatic int lw_of(input int max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    function automatic int csw_of(input int n_cs);
        return (n_cs > 1) ? $clog2(n_cs) : 1;
    endfunction

    localparam logic [7:0] JSTK_CMD_SET_LED    = 8'h84;
    localparam logic [7:0] JSTK_CMD_GET_STATUS = 8'hC0;

endpackage

// File: rtl/spi_byte_shifter.sv
// rtl/spi_byte_shifter.sv - one SPI mode-0 byte, MSB first, with the SCLK half-period divider
module spi_byte_shifter #(
    parameter int CLK_DIV = 50
) (
    input  logic       i_clk,
    input  logic       i_n_reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic            active;
    logic [DIVW-1:0] div_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      tx_sr;
    logic [7:0]      rx_sr;
    logic            half_end;

    assign half_end = (div_cnt == DIVW'(CLK_DIV - 1));
    assign done     = active && sclk && half_end && (bit_cnt == 3'd7);
    assign rx_byte  = rx_sr;
    // Before the byte starts, show its MSB so the slave sees it ahead of the first rising edge.
    assign mosi     = active ? tx_sr[7] : tx_byte[7];

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (start) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= tx_byte;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk  <= 1'b1;
                    rx_sr <= {rx_sr[6:0], miso};
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sr   <= {tx_sr[6:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_frame_master.sv
// rtl/spi_frame_master.sv - multi-byte SPI mode-0 frame engine with CS timing, multi-slave select and poll timer
module spi_frame_master
    import spi_frame_pkg::*;
#(
    parameter int CLK_DIV   = 50,
    parameter int MAX_BYTES = 8,
    parameter int CS_SETUP  = 1500,
    parameter int BYTE_GAP  = 1000,
    parameter int CS_HOLD   = 100,
    parameter int N_CS      = 2,
    parameter int POLL_CYC  = 0
) (
    input  logic                         i_clk,
    input  logic                         i_n_reset,
    input  logic                         i_start,
    input  logic [lw_of(MAX_BYTES)-1:0]  i_len,
    input  logic [csw_of(N_CS)-1:0]      i_cs_sel,
    input  logic [8*MAX_BYTES-1:0]       i_tx_data,
    input  logic                         i_poll_en,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [8*MAX_BYTES-1:0]       o_rx_data,
    output logic [N_CS-1:0]              o_cs_n,
    output logic                         o_sclk,
    output logic                         o_mosi,
    input  logic                         i_miso
);

    localparam int LW  = lw_of(MAX_BYTES);
    localparam int CSW = csw_of(N_CS);
    localparam int DW  = 8 * MAX_BYTES;

    state_t          state, state_nx;
    logic [31:0]     cnt;
    logic [LW-1:0]   len_q, idx, tx_idx;
    logic [CSW-1:0]  sel_q;
    logic [DW-1:0]   data_q, rx_buf, rx_nx;
    logic [7:0]      tx_byte, rx_byte;
    logic            accept, tick, last_byte, cs_active;
    logic            sh_start, sh_done, sh_mosi;

    assign accept    = (state == S_IDLE) && (i_start || tick) && (i_len != '0) &&
                       ({1'b0, i_cs_sel} < (CSW+1)'(N_CS));
    assign last_byte = (idx == len_q - 1'b1);
    // With no gap the next byte is loaded in the same cycle the current one ends.
    assign tx_idx    = (state == S_SHIFT && BYTE_GAP == 0) ? idx + 1'b1 : idx;
    assign tx_byte   = 8'(data_q >> {tx_idx, 3'b000});
    assign cs_active = (state == S_SETUP) || (state == S_SHIFT) || (state == S_GAP) || (state == S_HOLD);

    always_comb begin
        state_nx = state;
        sh_start = 1'b0;
        unique case (state)
            S_IDLE:  if (accept) state_nx = S_SETUP;
            S_SETUP: if (cnt == 32'(CS_SETUP - 1)) begin
                state_nx = S_SHIFT;
                sh_start = 1'b1;
            end
            S_SHIFT: if (sh_done) begin
                if (last_byte)          state_nx = (CS_HOLD == 0) ? S_DONE : S_HOLD;
                else if (BYTE_GAP == 0) sh_start = 1'b1;
                else                    state_nx = S_GAP;
            end
            S_GAP:   if (cnt == 32'(BYTE_GAP - 1)) begin
                state_nx = S_SHIFT;
                sh_start = 1'b1;
            end
            S_HOLD:  if (cnt == 32'(CS_HOLD - 1)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        rx_nx = rx_buf;
        if (sh_done) rx_nx[8*idx +: 8] = rx_byte;
    end

    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            len_q     <= '0;
            idx       <= '0;
            sel_q     <= '0;
            data_q    <= '0;
            rx_buf    <= '0;
            o_rx_data <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? '0 : cnt + 1'b1;
            if (accept) begin
                len_q  <= (i_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : i_len;
                sel_q  <= i_cs_sel;
                data_q <= i_tx_data;
                idx    <= '0;
                rx_buf <= '0;
            end else begin
                rx_buf <= rx_nx;
                if (sh_done && !last_byte) idx <= idx + 1'b1;
            end
            if (state_nx == S_DONE && state != S_DONE) o_rx_data <= rx_nx;
        end
    end

    generate
        if (POLL_CYC > 0) begin : g_poll
            logic [31:0] poll_cnt;
            assign tick = i_poll_en && (poll_cnt == 32'(POLL_CYC - 1));
            // Restart on every accept so the period is start-to-start; a dropped tick also restarts it.
            always_ff @(posedge i_clk or negedge i_n_reset) begin
                if (!i_n_reset)                          poll_cnt <= '0;
                else if (!i_poll_en || accept || tick)   poll_cnt <= '0;
                else                                     poll_cnt <= poll_cnt + 1'b1;
            end
        end else begin : g_no_poll
            logic unused_poll_en;
            assign unused_poll_en = i_poll_en;
            assign tick = 1'b0;
        end
    endgenerate

    always_comb begin
        o_cs_n = '1;
        for (int i = 0; i < N_CS; i++) begin
            if (cs_active && sel_q == CSW'(i)) o_cs_n[i] = 1'b0;
        end
    end

    assign o_busy = (state != S_IDLE);
    assign o_done = (state == S_DONE);
    assign o_mosi = cs_active ? sh_mosi : 1'b0;

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clk     (i_clk),
        .i_n_reset (i_n_reset),
        .start     (sh_start),
        .tx_byte   (tx_byte),
        .rx_byte   (rx_byte),
        .done      (sh_done),
        .sclk      (o_sclk),
        .mosi      (sh_mosi),
        .miso      (i_miso)
    );

endmodule

// File: tb/tb_spi_frame_master.sv
// tb/tb_spi_frame_master.sv - directed vector bench for spi_frame_master
module tb_spi_frame_master;
    import spi_frame_pkg::*;

    localparam int CLK_DIV = 2, CS_SETUP = 4, BYTE_GAP = 3, CS_HOLD = 2, MAXB = 8, N_CS = 2;

    typedef struct {
        logic [3:0]  len;
        logic        sel;
        logic [63:0] tx;
        logic        loop;
        logic [63:0] rx;
        int          cyc;
        int          rises;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        start = 1'b0, poll_en = 1'b0, loop = 1'b1;
    logic [3:0]  len = '0;
    logic [0:0]  sel = '0;
    logic [63:0] tx = '0;
    logic        busy, done, sclk, mosi, miso;
    logic [63:0] rx;
    logic [1:0]  cs_n, exp_cs = 2'b10;

    logic        start1 = 1'b0, poll1 = 1'b0;
    logic [3:0]  len1 = 4'd2;
    logic [0:0]  sel1 = '0;
    logic [63:0] tx1 = '0;
    logic        busy1, done1, sclk1, mosi1;
    logic [63:0] rx1;
    logic [1:0]  cs_n1;

    int cyc = 0, n_checks = 0, n_fail = 0;
    int rise_cnt = 0, done_cnt = 0, done_cyc = 0, busy_rises = 0, cs_bad = 0, cs_low = 0, done1_cnt = 0;
    logic sclk_prev = 1'b0, busy_prev = 1'b0, busy1_prev = 1'b0;
    logic mosi_q[$];
    int   acc1_q[$];
    vec_t vecs[5];

    assign miso = loop ? mosi : 1'b1;

    spi_frame_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAXB), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP),
                       .CS_HOLD(CS_HOLD), .N_CS(N_CS), .POLL_CYC(0)) dut (
        .i_clk(clk), .i_n_reset(rst_n), .i_start(start), .i_len(len), .i_cs_sel(sel), .i_tx_data(tx),
        .i_poll_en(poll_en), .o_busy(busy), .o_done(done), .o_rx_data(rx), .o_cs_n(cs_n),
        .o_sclk(sclk), .o_mosi(mosi), .i_miso(miso));

    spi_frame_master #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAXB), .CS_SETUP(CS_SETUP), .BYTE_GAP(BYTE_GAP),
                       .CS_HOLD(CS_HOLD), .N_CS(N_CS), .POLL_CYC(200)) dut_poll (
        .i_clk(clk), .i_n_reset(rst_n), .i_start(start1), .i_len(len1), .i_cs_sel(sel1), .i_tx_data(tx1),
        .i_poll_en(poll1), .o_busy(busy1), .o_done(done1), .o_rx_data(rx1), .o_cs_n(cs_n1),
        .o_sclk(sclk1), .o_mosi(mosi1), .i_miso(1'b0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sclk && !sclk_prev) begin
            rise_cnt++;
            mosi_q.push_back(mosi);
        end
        sclk_prev = sclk;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy && !busy_prev) busy_rises++;
        busy_prev = busy;
        if (cs_n != 2'b11) cs_low++;
        if (cs_n != 2'b11 && cs_n != exp_cs) cs_bad++;
        if (busy1 && !busy1_prev) acc1_q.push_back(cyc);
        busy1_prev = busy1;
        if (done1) done1_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        rise_cnt = 0; done_cnt = 0; done_cyc = 0; busy_rises = 0; cs_bad = 0; cs_low = 0;
        mosi_q.delete();
    endtask

    task automatic launch(input vec_t v, output int t0);
        clear_mon();
        loop = v.loop; len = v.len; sel = v.sel; tx = v.tx;
        exp_cs = v.sel ? 2'b01 : 2'b10;
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    endtask

    function automatic int mosi_errs(input vec_t v);
        int nb, errs;
        nb = (v.len > 4'd8) ? 8 : int'(v.len);
        errs = 0;
        if (mosi_q.size() != nb * 8) return 1000;
        for (int i = 0; i < nb * 8; i++) begin
            if (mosi_q[i] !== v.tx[8 * (i / 8) + 7 - (i % 8)]) errs++;
        end
        return errs;
    endfunction

    task automatic check_frame(input string tag, input vec_t v, input int t0);
        check({tag, " rx_data"}, rx, v.rx);
        check({tag, " latency"}, 64'(done_cyc - t0), 64'(v.cyc));
        check({tag, " sclk_rises"}, 64'(rise_cnt), 64'(v.rises));
        check({tag, " done_count"}, 64'(done_cnt), 64'd1);
        check({tag, " wrong_cs"}, 64'(cs_bad), 64'd0);
        check({tag, " cs_asserted"}, 64'(cs_low != 0), 64'd1);
        check({tag, " mosi_bits"}, 64'(mosi_errs(v)), 64'd0);
    endtask

    initial begin
        int t0, a0, a1, a2;
        vecs[0] = '{4'd5, 1'b0, 64'h0000_0044_3322_1184, 1'b1, 64'h0000_0044_3322_1184, 179, 40};
        vecs[1] = '{4'd1, 1'b0, 64'h0000_0000_0000_00A5, 1'b0, 64'h0000_0000_0000_00FF, 39, 8};
        vecs[2] = '{4'd9, 1'b1, 64'h8877_6655_4433_2211, 1'b1, 64'h8877_6655_4433_2211, 284, 64};
        vecs[3] = '{4'd2, 1'b1, {48'h0, JSTK_CMD_GET_STATUS, JSTK_CMD_SET_LED}, 1'b0, 64'h0000_0000_0000_FFFF, 74, 16};
        vecs[4] = '{4'd3, 1'b0, 64'hDEAD_BEEF_A1B2_C3D4, 1'b1, 64'h0000_0000_00B2_C3D4, 109, 24};

        repeat (3) @(negedge clk);
        check("reset cs_n", 64'(cs_n), 64'h3);
        check("reset sclk", 64'(sclk), 64'h0);
        check("reset mosi", 64'(mosi), 64'h0);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(done), 64'h0);
        check("reset rx", rx, 64'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            launch(vecs[i], t0);
            wait_done();
            repeat (20) @(negedge clk);
            check_frame($sformatf("vec%0d", i), vecs[i], t0);
        end

        // len=0 must not start anything
        clear_mon();
        len = 4'd0; sel = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("len0 busy_rises", 64'(busy_rises), 64'd0);
        check("len0 cs_activity", 64'(cs_low), 64'd0);
        check("len0 done", 64'(done_cnt), 64'd0);

        // restart request mid-frame and tx change after accept
        launch(vecs[0], t0);
        repeat (50) @(negedge clk);
        start = 1'b1; tx = 64'hFFFF_FFFF_FFFF_FFFF; len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (200) @(negedge clk);
        check("restart done_count", 64'(done_cnt), 64'd1);
        check("restart busy_rises", 64'(busy_rises), 64'd1);
        check("restart rx_data", rx, vecs[0].rx);
        check("restart latency", 64'(done_cyc - t0), 64'd179);
        check("restart mosi_bits", 64'(mosi_errs(vecs[0])), 64'd0);

        // reset during the third byte
        launch(vecs[0], t0);
        for (int i = 0; i < 2000 && rise_cnt < 18; i++) @(negedge clk);
        check("midreset reached byte2", 64'(rise_cnt >= 18), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midreset cs_n", 64'(cs_n), 64'h3);
        check("midreset sclk", 64'(sclk), 64'h0);
        check("midreset busy", 64'(busy), 64'h0);
        check("midreset rx", rx, 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset no_done", 64'(done_cnt), 64'd0);
        launch(vecs[1], t0);
        wait_done();
        repeat (10) @(negedge clk);
        check_frame("after_reset", vecs[1], t0);

        // poll mode on the second instance
        tx1 = {48'h0, JSTK_CMD_GET_STATUS, JSTK_CMD_SET_LED};
        acc1_q.delete();
        done1_cnt = 0;
        t0 = cyc;
        poll1 = 1'b1;
        for (int i = 0; i < 1500 && acc1_q.size() < 3; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        poll1 = 1'b0;
        repeat (600) @(negedge clk);
        a0 = (acc1_q.size() > 0) ? acc1_q[0] : -1;
        a1 = (acc1_q.size() > 1) ? acc1_q[1] : -1;
        a2 = (acc1_q.size() > 2) ? acc1_q[2] : -1;
        check("poll accepts", 64'(acc1_q.size()), 64'd3);
        check("poll first", 64'(a0 - t0), 64'd200);
        check("poll period1", 64'(a1 - a0), 64'd200);
        check("poll period2", 64'(a2 - a1), 64'd200);
        check("poll dones", 64'(done1_cnt), 64'd3);
        check("poll rx", rx1, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
